// File: rtl/pam4_error_burst_monitor.sv
// PAM4 tx/rx alignment FIFO, symbol/bit error counters, burst FSM with length histogram, registered stats read port.
// Define GRAY_DEMAP_EN to count bit errors after Gray demapping instead of natural binary.
module pam4_error_burst_monitor #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 48,
  parameter int HIST_BINS  = 16,
  parameter int BURST_GAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       tx_symbol,
  input  logic             tx_valid,
  input  logic [1:0]       rx_symbol,
  input  logic             rx_valid,
  input  logic             clear,
  input  logic [5:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             fifo_overflow,
  output logic             fifo_underflow,
  output logic             in_burst
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  logic [1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_sym_cnt, r_serr_cnt, r_berr_cnt, r_burst_cnt;
  logic [CNT_W-1:0] r_hist [HIST_BINS];
  logic [15:0]      r_max, r_run, r_gap;
  logic             r_ovf, r_unf;
  state_t           r_state;

  logic             w_full, w_empty, w_pop, w_push, w_err, w_close;
  logic [1:0]       w_head, w_diff, w_bits;
  logic [15:0]      w_gap_nxt, w_len, w_run_inc;
  logic [4:0]       w_bin;
  logic [CNT_W-1:0] w_rd;

  function automatic logic [1:0] f_map(input logic [1:0] s);
`ifdef GRAY_DEMAP_EN
    f_map = {s[1], s[1] ^ s[0]};
`else
    f_map = s;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    f_sat_add = s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = rx_valid && !w_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts a push
  assign w_push    = tx_valid && (!w_full || w_pop);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_err     = (w_head != rx_symbol);
  assign w_diff    = f_map(w_head) ^ f_map(rx_symbol);
  assign w_bits    = {1'b0, w_diff[1]} + {1'b0, w_diff[0]};
  assign w_gap_nxt = r_gap + 16'd1;
  assign w_run_inc = (r_run == 16'hFFFF) ? r_run : r_run + 16'd1;
  assign w_len     = r_run - r_gap;
  assign w_close   = w_pop && !w_err && (r_state != S_IDLE) && (w_gap_nxt >= 16'(BURST_GAP));
  assign w_bin     = (w_len >= 16'(HIST_BINS)) ? 5'(HIST_BINS - 1) : 5'(w_len - 16'd1);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_symbol;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_sym_cnt   <= '0;
      r_serr_cnt  <= '0;
      r_berr_cnt  <= '0;
      r_burst_cnt <= '0;
      for (int i = 0; i < HIST_BINS; i++) r_hist[i] <= '0;
      r_max   <= '0;
      r_run   <= '0;
      r_gap   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      if (tx_valid && w_full && !w_pop) r_ovf <= 1'b1;
      if (rx_valid && w_empty)          r_unf <= 1'b1;
      if (w_pop) begin
        r_sym_cnt <= f_sat_add(r_sym_cnt, 2'd1);
        if (w_err) begin
          r_serr_cnt <= f_sat_add(r_serr_cnt, 2'd1);
          r_berr_cnt <= f_sat_add(r_berr_cnt, w_bits);
        end
        case (r_state)
          S_IDLE: if (w_err) begin
            r_state <= S_BURST;
            r_run   <= 16'd1;
            r_gap   <= '0;
          end
          S_BURST: begin
            r_run <= w_run_inc;
            if (!w_err) begin
              r_state <= S_GAP;
              r_gap   <= 16'd1;
            end
          end
          default: begin
            r_run <= w_run_inc;
            if (w_err) begin
              r_state <= S_BURST;
              r_gap   <= '0;
            end else begin
              r_gap <= w_gap_nxt;
            end
          end
        endcase
        // Closing overrides the tentative run/gap updates above
        if (w_close) begin
          r_state     <= S_IDLE;
          r_run       <= '0;
          r_gap       <= '0;
          r_burst_cnt <= f_sat_add(r_burst_cnt, 2'd1);
          for (int i = 0; i < HIST_BINS; i++)
            if (w_bin == 5'(i)) r_hist[i] <= f_sat_add(r_hist[i], 2'd1);
          if (w_len > r_max) r_max <= w_len;
        end
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (rd_addr)
      6'd0: w_rd = r_sym_cnt;
      6'd1: w_rd = r_serr_cnt;
      6'd2: w_rd = r_berr_cnt;
      6'd3: w_rd = r_burst_cnt;
      6'd4: w_rd = CNT_W'(r_max);
      default: begin
        for (int i = 0; i < HIST_BINS; i++)
          if (rd_addr == 6'(32 + i)) w_rd = r_hist[i];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= w_rd;
  end

  assign fifo_overflow  = r_ovf;
  assign fifo_underflow = r_unf;
  assign in_burst       = (r_state != S_IDLE);
endmodule

// File: tb/tb_pam4_error_burst_monitor.sv
// Scoreboard bench: stimulus pushes expected read results from a sequence-level model; a monitor pops and compares.
module tb_pam4_error_burst_monitor;
  localparam int DEPTH = 8;
  localparam int CW    = 48;
  localparam int HB    = 16;
  localparam int BG    = 2;

  logic          clk = 1'b0;
  logic          rst, tx_valid, rx_valid, clear, rd_req, req_d;
  logic [1:0]    tx_symbol, rx_symbol;
  logic [5:0]    rd_addr;
  logic [CW-1:0] rd_data;
  logic          fifo_overflow, fifo_underflow, in_burst;

  pam4_error_burst_monitor #(.FIFO_DEPTH(DEPTH), .CNT_W(CW), .HIST_BINS(HB), .BURST_GAP(BG)) dut (
    .clk(clk), .rst(rst), .tx_symbol(tx_symbol), .tx_valid(tx_valid),
    .rx_symbol(rx_symbol), .rx_valid(rx_valid), .clear(clear), .rd_addr(rd_addr),
    .rd_data(rd_data), .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
    .in_burst(in_burst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of outstanding tx symbols, bursts tracked by error positions
  int     mq[$];
  longint m_sym, m_se, m_be, m_bc, m_max, m_idx, m_first, m_last;
  longint m_hist[HB];
  bit     m_ovf, m_unf, m_open;

  typedef struct {
    logic [5:0]    addr;
    logic [CW-1:0] data;
    bit            ovf, unf, inb;
  } exp_t;
  exp_t sb[$];

  function automatic int model_map(input int s);
`ifdef GRAY_DEMAP_EN
    int g[4] = '{0, 1, 3, 2};
    return g[s];
`else
    return s;
`endif
  endfunction

  task automatic model_clear();
    m_sym = 0; m_se = 0; m_be = 0; m_bc = 0; m_max = 0;
    m_idx = 0; m_first = 0; m_last = 0;
    for (int i = 0; i < HB; i++) m_hist[i] = 0;
    m_ovf = 0; m_unf = 0; m_open = 0;
  endtask

  function automatic longint model_read(input int a);
    if (a == 0) return m_sym;
    if (a == 1) return m_se;
    if (a == 2) return m_be;
    if (a == 3) return m_bc;
    if (a == 4) return m_max;
    if (a >= 32 && a < 32 + HB) return m_hist[a - 32];
    return 0;
  endfunction

  task automatic model_accept(input int h, input int r);
    longint len;
    bit e;
    e = (h != r);
    m_sym++;
    if (e) begin
      m_se++;
      m_be += $countones(2'(model_map(h) ^ model_map(r)));
      if (!m_open) begin
        m_open  = 1;
        m_first = m_idx;
      end
      m_last = m_idx;
    end else if (m_open && (m_idx - m_last) >= BG) begin
      len = m_last - m_first + 1;
      m_bc++;
      m_hist[(len > HB ? HB : len) - 1]++;
      if (len > m_max) m_max = len;
      m_open = 0;
    end
    m_idx++;
  endtask

  task automatic model_step(input bit tv, input int ts, input bit rv, input int rs, input bit clr);
    bit popped, push;
    int head;
    popped = rv && (mq.size() > 0);
    head   = popped ? mq[0] : 0;
    push   = tv && ((mq.size() < DEPTH) || popped);
    if (clr) model_clear();
    else begin
      if (rv && mq.size() == 0) m_unf = 1;
      if (tv && !push) m_ovf = 1;
      if (popped) model_accept(head, rs);
    end
    if (popped) void'(mq.pop_front());
    if (push) mq.push_back(ts);
  endtask

  task automatic cyc(input bit tv, input int ts, input bit rv, input int rs,
                     input bit clr, input bit rq, input int ra);
    exp_t e;
    tx_valid = tv; tx_symbol = 2'(ts); rx_valid = rv; rx_symbol = 2'(rs);
    clear = clr; rd_req = rq; rd_addr = 6'(ra);
    e.addr = 6'(ra);
    e.data = CW'(model_read(ra));
    model_step(tv, ts, rv, rs, clr);
    if (rq) begin
      e.ovf = m_ovf; e.unf = m_unf; e.inb = m_open;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic rd(input int a);
    cyc(0, 0, 0, 0, 0, 1, a);
  endtask

  task automatic rd_main();
    for (int a = 0; a < 5; a++) rd(a);
  endtask

  task automatic do_reset();
    rst = 1; tx_valid = 0; rx_valid = 0; clear = 0; rd_req = 0;
    tx_symbol = 0; rx_symbol = 0; rd_addr = 0;
    mq.delete();
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic sym_pair(input bit err);
    int t, r;
    t = $urandom_range(0, 3);
    r = err ? (t ^ $urandom_range(1, 3)) : t;
    cyc(1, t, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, r, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) req_d <= rd_req;

  always @(negedge clk) begin
    if (req_d === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty got=read expected=none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("rd_data[%0d]", e.addr), longint'(rd_data), longint'(e.data));
        chk("fifo_overflow", longint'(fifo_overflow), longint'(e.ovf));
        chk("fifo_underflow", longint'(fifo_underflow), longint'(e.unf));
        chk("in_burst", longint'(in_burst), longint'(e.inb));
      end
    end
  end

  initial begin
    int txs[6];
    do_reset();
    rd_main(); rd(32); rd(47); rd(63);

    // Matched stream, rx one cycle behind tx
    for (int i = 0; i <= 400; i++)
      cyc(i < 400, i % 4, i > 0, (i + 3) % 4, 0, 0, 0);
    rd_main();

    // Single 00 vs 11 error
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) sym_pair(0);
    rd_main(); rd(32);

    // E,C,E,C,C with a read between symbols to observe in_burst
    do_reset();
    sym_pair(1); rd(3); sym_pair(0); rd(3); sym_pair(1); rd(3);
    sym_pair(0); rd(3); sym_pair(0); rd(3); rd(34); rd(4);

    // Long burst lands in the last bin
    for (int i = 0; i < 20; i++) sym_pair(1);
    rd(4);
    for (int i = 0; i < BG; i++) sym_pair(0);
    rd(47); rd(4); rd(3);

    // Underflow, then overflow and drain
    do_reset();
    cyc(0, 0, 1, 2, 0, 0, 0);
    rd(0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1, $urandom_range(0, 3), 0, 0, 0, 0, 0);
    rd(0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, $urandom_range(0, 3), 0, 0, 0);
    rd_main();

    // Clear mid-burst with FIFO entries outstanding
    do_reset();
    for (int i = 0; i < 6; i++) begin
      txs[i] = $urandom_range(0, 3);
      cyc(1, txs[i], 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, txs[i] ^ 1, 0, 0, 0);
    rd(3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    rd_main();
    for (int a = 32; a < 32 + HB; a++) rd(a);
    for (int i = 3; i < 6; i++) cyc(0, 0, 1, txs[i], 0, 0, 0);
    rd_main();

    // Randomized traffic with mostly matched symbols
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit tv, rv, clr, rq;
      int ts, rs, a, pick;
      tv  = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 3) != 0);
      ts  = $urandom_range(0, 3);
      rs  = (mq.size() > 0 && $urandom_range(0, 4) != 0) ? mq[0] : $urandom_range(0, 3);
      clr = ($urandom_range(0, 99) == 0);
      if (clr) begin
        tv = 0;
        if (mq.size() == 0) rv = 0;
      end
      rq   = ($urandom_range(0, 2) == 0);
      pick = $urandom_range(0, 2);
      a    = (pick == 0) ? $urandom_range(0, 4) :
             (pick == 1) ? 32 + $urandom_range(0, HB - 1) : $urandom_range(0, 63);
      cyc(tv, ts, rv, rs, clr, rq, a);
    end
    rd_main();
    for (int a = 32; a < 32 + HB; a++) rd(a);

    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
